// File: rtl/gte_cop2_sequencer_if.sv
// CPU-side COP2 request port and engine-side register/command port of the GTE sequencer.
// The sequencer attaches through the slave modport; the CPU/engine side uses master.
interface gte_cop2_sequencer_if;
    // CPU side
    logic        i_cpuReq;
    logic [1:0]  i_cpuOp;
    logic [5:0]  i_cpuRegID;
    logic [31:0] i_cpuData;
    logic [24:0] i_cpuInstr;
    logic        o_cpuAck;
    logic        o_cpuStall;
    logic [31:0] o_cpuRdData;
    logic        o_cpuRdValid;
    // Engine side
    logic [5:0]  o_regID;
    logic        o_WritReg;
    logic        o_ReadReg;
    logic [31:0] o_dataIn;
    logic [24:0] o_Instruction;
    logic        o_run;
    logic [31:0] i_dataOut;
    logic        i_operationForbidden;
    // Status
    logic [15:0] o_stallCount;
    logic        o_seqState;

    modport master (
        output i_cpuReq, i_cpuOp, i_cpuRegID, i_cpuData, i_cpuInstr,
        output i_dataOut, i_operationForbidden,
        input  o_cpuAck, o_cpuStall, o_cpuRdData, o_cpuRdValid,
        input  o_regID, o_WritReg, o_ReadReg, o_dataIn, o_Instruction, o_run,
        input  o_stallCount, o_seqState
    );

    modport slave (
        input  i_cpuReq, i_cpuOp, i_cpuRegID, i_cpuData, i_cpuInstr,
        input  i_dataOut, i_operationForbidden,
        output o_cpuAck, o_cpuStall, o_cpuRdData, o_cpuRdValid,
        output o_regID, o_WritReg, o_ReadReg, o_dataIn, o_Instruction, o_run,
        output o_stallCount, o_seqState
    );
endinterface

// File: rtl/gte_cop2_sequencer.sv
// Sequences CPU COP2 writes/commands through a 2-entry in-order queue into the GTE and serves reads.
// Optional stall counter enabled by defining GTE_SEQ_STALL_COUNTER_EN.
module gte_cop2_sequencer (
    input  logic                 i_clk,
    input  logic                 i_rst,
    gte_cop2_sequencer_if.slave  seqBus
);
    // Handshake: a CPU request is taken in any cycle where i_cpuReq && o_cpuAck;
    // otherwise o_cpuStall is high and the CPU must hold the request unchanged.
    typedef enum logic {IDLE = 1'b0, GUARD = 1'b1} state_t;

    typedef struct packed {
        logic        isCmd;
        logic [5:0]  regID;
        logic [31:0] payload;
    } entry_t;

    state_t      state;
    entry_t      fifo [2];
    logic [1:0]  count;
    logic [31:0] rdData;
    logic        rdValid;

    logic        isPushOp;
    logic        issue;
    logic        issueWrite;
    logic        issueCmd;
    logic        readAccept;
    logic        pushAck;
    logic        ignoreAck;
    logic        ack;
    logic        stall;
    logic        pushIdx;
    entry_t      newEntry;

    assign isPushOp   = (seqBus.i_cpuOp == 2'd0) || (seqBus.i_cpuOp == 2'd2);
    // The head is issued from registered queue state only, so a push is never bypassed.
    assign issue      = !i_rst && (state == IDLE) && (count != 2'd0) && !seqBus.i_operationForbidden;
    assign issueWrite = issue && !fifo[0].isCmd;
    assign issueCmd   = issue && fifo[0].isCmd;
    assign readAccept = !i_rst && seqBus.i_cpuReq && (seqBus.i_cpuOp == 2'd1) && (state == IDLE)
                        && (count == 2'd0) && !seqBus.i_operationForbidden;
    assign pushAck    = !i_rst && seqBus.i_cpuReq && isPushOp && (count != 2'd2);
    assign ignoreAck  = !i_rst && seqBus.i_cpuReq && (seqBus.i_cpuOp == 2'd3);
    assign ack        = pushAck || readAccept || ignoreAck;
    assign stall      = !i_rst && seqBus.i_cpuReq && !ack;

    // With a simultaneous pop the new entry lands one slot lower.
    assign pushIdx    = issue ? 1'b0 : count[0];

    always_comb begin
        newEntry         = '0;
        newEntry.isCmd   = seqBus.i_cpuOp[1];
        newEntry.regID   = seqBus.i_cpuRegID;
        newEntry.payload = seqBus.i_cpuOp[1] ? {7'd0, seqBus.i_cpuInstr} : seqBus.i_cpuData;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            count   <= 2'd0;
            fifo[0] <= '0;
            fifo[1] <= '0;
            rdData  <= 32'd0;
            rdValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (issueCmd) state <= GUARD;
                GUARD:   state <= IDLE;
                default: state <= IDLE;
            endcase

            if (issue)   fifo[0]       <= fifo[1];
            if (pushAck) fifo[pushIdx] <= newEntry;

            unique case ({pushAck, issue})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            rdValid <= readAccept;
            if (readAccept) rdData <= seqBus.i_dataOut;
        end
    end

    assign seqBus.o_cpuAck      = ack;
    assign seqBus.o_cpuStall    = stall;
    assign seqBus.o_cpuRdData   = i_rst ? 32'd0 : rdData;
    assign seqBus.o_cpuRdValid  = rdValid && !i_rst;
    assign seqBus.o_WritReg     = issueWrite;
    assign seqBus.o_ReadReg     = readAccept;
    assign seqBus.o_run         = issueCmd;
    assign seqBus.o_regID       = issueWrite ? fifo[0].regID :
                                  readAccept ? seqBus.i_cpuRegID : 6'd0;
    assign seqBus.o_dataIn      = issueWrite ? fifo[0].payload : 32'd0;
    assign seqBus.o_Instruction = issueCmd ? fifo[0].payload[24:0] : 25'd0;
    assign seqBus.o_seqState    = (state == GUARD) && !i_rst;

`ifdef GTE_SEQ_STALL_COUNTER_EN
    logic [15:0] stallCount;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stallCount <= 16'd0;
        end else if (stall && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

    assign seqBus.o_stallCount = i_rst ? 16'd0 : stallCount;
`else
    assign seqBus.o_stallCount = 16'd0;
`endif
endmodule

// File: tb/tb_gte_cop2_sequencer.sv
// Directed and random stimulus for gte_cop2_sequencer, checked every cycle against a
// queue-based behavioural model of the sequencer.
module tb_gte_cop2_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gte_cop2_sequencer_if bus ();

    gte_cop2_sequencer dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .seqBus (bus)
    );

    typedef struct {
        bit        isCmd;
        bit [5:0]  rid;
        bit [31:0] pay;
    } ent_t;

    // Behavioural model state
    ent_t        mq[$];
    bit          mGuard;
    bit          mRdValid;
    logic [31:0] mRdData;
    int          mStall;
    logic [31:0] exp_q[$];

    int nTests = 0;
    int nFail  = 0;
    bit lastAck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare one cycle of DUT outputs against the model, then advance the model.
    task automatic tick();
        bit          issue, rdAcc, ack, stall, req, busy;
        bit [1:0]    op;
        ent_t        head;
        logic [31:0] expReg, expData, expInstr, expCnt, gotRd;
        @(negedge clk);
        req  = bus.i_cpuReq;
        op   = bus.i_cpuOp;
        busy = bus.i_operationForbidden;
        head.isCmd = 1'b0; head.rid = '0; head.pay = '0;
        if (mq.size() > 0) head = mq[0];
        issue = !rst && !mGuard && (mq.size() > 0) && !busy;
        rdAcc = !rst && req && (op == 2'd1) && !mGuard && (mq.size() == 0) && !busy;
        case (op)
            2'd0, 2'd2: ack = (mq.size() < 2);
            2'd1:       ack = rdAcc;
            default:    ack = 1'b1;
        endcase
        ack   = ack && req && !rst;
        stall = !rst && req && !ack;

        expReg   = (issue && !head.isCmd) ? {26'd0, head.rid} : rdAcc ? {26'd0, bus.i_cpuRegID} : 32'd0;
        expData  = (issue && !head.isCmd) ? head.pay : 32'd0;
        expInstr = (issue && head.isCmd) ? {7'd0, head.pay[24:0]} : 32'd0;
`ifdef GTE_SEQ_STALL_COUNTER_EN
        expCnt = rst ? 32'd0 : mStall;
`else
        expCnt = 32'd0;
`endif
        check("ack",      bus.o_cpuAck, ack);
        check("stall",    bus.o_cpuStall, stall);
        check("writReg",  bus.o_WritReg, issue && !head.isCmd);
        check("run",      bus.o_run, issue && head.isCmd);
        check("readReg",  bus.o_ReadReg, rdAcc);
        check("regID",    {26'd0, bus.o_regID}, expReg);
        check("dataIn",   bus.o_dataIn, expData);
        check("instr",    {7'd0, bus.o_Instruction}, expInstr);
        check("rdValid",  bus.o_cpuRdValid, rst ? 1'b0 : mRdValid);
        check("rdData",   bus.o_cpuRdData, rst ? 32'd0 : mRdData);
        check("stallCnt", {16'd0, bus.o_stallCount}, expCnt);
        check("exclusive", $countones({bus.o_WritReg, bus.o_ReadReg, bus.o_run}) <= 1, 1'b1);
        if (bus.o_cpuRdValid === 1'b1 && exp_q.size() > 0) begin
            gotRd = exp_q.pop_front();
            check("sbRead", bus.o_cpuRdData, gotRd);
        end
        lastAck = bus.o_cpuAck;

        if (rst) begin
            mq.delete();
            exp_q.delete();
            mGuard = 0; mRdValid = 0; mRdData = '0; mStall = 0;
        end else begin
            if (issue) void'(mq.pop_front());
            mGuard = issue && head.isCmd;
            if (ack && (op == 2'd0 || op == 2'd2)) begin
                head.isCmd = op[1];
                head.rid   = bus.i_cpuRegID;
                head.pay   = op[1] ? {7'd0, bus.i_cpuInstr} : bus.i_cpuData;
                mq.push_back(head);
            end
            mRdValid = rdAcc;
            if (rdAcc) begin
                mRdData = bus.i_dataOut;
                exp_q.push_back(bus.i_dataOut);
            end
            if (stall && mStall < 65535) mStall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit req, input bit [1:0] op, input bit [5:0] rid, input bit [31:0] data,
                        input bit [24:0] ins, input bit busy, input bit [31:0] dOut);
        bus.i_cpuReq             = req;
        bus.i_cpuOp              = op;
        bus.i_cpuRegID           = rid;
        bus.i_cpuData            = data;
        bus.i_cpuInstr           = ins;
        bus.i_operationForbidden = busy;
        bus.i_dataOut            = dOut;
        tick();
    endtask

    task automatic idle(input bit busy);
        step(1'b0, 2'($urandom), 6'($urandom), $urandom, 25'($urandom), busy, $urandom);
    endtask

    // Hold one request until accepted, with a bounded cycle budget.
    task automatic holdUntilAck(input bit [1:0] op, input bit [5:0] rid, input bit [31:0] data,
                                input bit [24:0] ins, input bit busy, input bit [31:0] dOut);
        lastAck = 1'b0;
        for (int k = 0; k < 30 && !lastAck; k++) step(1'b1, op, rid, data, ins, busy, dOut);
        if (!lastAck) check("ackTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        mGuard = 0; mRdValid = 0; mRdData = '0; mStall = 0;
        // Reset with live requests: all outputs must read zero.
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'($urandom), 6'($urandom), $urandom, 25'($urandom), 1'b0, $urandom);
        rst = 1'b0;

        // Single write, issue one cycle after ack.
        step(1'b1, 2'd0, 6'd1, 32'h12345678, 25'd0, 1'b0, $urandom);
        idle(1'b0);
        idle(1'b0);

        // Command then write with engine idle: the GUARD cycle blocks the write.
        step(1'b1, 2'd2, 6'd0, 32'd0, 25'h0000001, 1'b0, $urandom);
        step(1'b1, 2'd0, 6'd2, 32'hAAAA5555, 25'd0, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Command then write with engine busy for 10 cycles after run.
        step(1'b1, 2'd2, 6'd0, 32'd0, 25'h0000001, 1'b0, $urandom);
        step(1'b1, 2'd0, 6'd2, 32'h0BADF00D, 25'd0, 1'b0, $urandom);
        for (int i = 0; i < 10; i++) idle(1'b1);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Three writes with busy high: the third stalls, and is not taken on the pop cycle.
        step(1'b1, 2'd0, 6'd10, 32'h00000001, 25'd0, 1'b1, $urandom);
        step(1'b1, 2'd0, 6'd11, 32'h00000002, 25'd0, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 6'd12, 32'h00000003, 25'd0, 1'b1, $urandom);
        holdUntilAck(2'd0, 6'd12, 32'h00000003, 25'd0, 1'b0, $urandom);
        for (int i = 0; i < 4; i++) idle(1'b0);

        // Read with empty queue.
        step(1'b1, 2'd1, 6'd7, 32'd0, 25'd0, 1'b0, 32'hDEADBEEF);
        check("read031", bus.o_cpuRdData, 32'hDEADBEEF);
        idle(1'b0);
        check("rdHold", bus.o_cpuRdData, 32'hDEADBEEF);

        // Read behind a queued write.
        step(1'b1, 2'd0, 6'd3, 32'hCAFEF00D, 25'd0, 1'b0, $urandom);
        holdUntilAck(2'd1, 6'd3, 32'd0, 25'd0, 1'b0, 32'h13579BDF);
        idle(1'b0);

        // Ignored op.
        step(1'b1, 2'd3, 6'd5, 32'hFFFFFFFF, 25'h1FFFFFF, 1'b0, $urandom);
        step(1'b1, 2'd3, 6'd5, 32'hFFFFFFFF, 25'h1FFFFFF, 1'b1, $urandom);
        idle(1'b0);

        // Stall counter: fresh reset, fill queue, stall 5 cycles, reset, then read at once.
        rst = 1'b1; idle(1'b0); rst = 1'b0;
        step(1'b1, 2'd0, 6'd20, 32'h1, 25'd0, 1'b1, $urandom);
        step(1'b1, 2'd0, 6'd21, 32'h2, 25'd0, 1'b1, $urandom);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 6'd22, 32'h3, 25'd0, 1'b1, $urandom);
`ifdef GTE_SEQ_STALL_COUNTER_EN
        check("stallCnt5", {16'd0, bus.o_stallCount}, 32'd5);
`else
        check("stallCnt0", {16'd0, bus.o_stallCount}, 32'd0);
`endif
        rst = 1'b1; idle(1'b1); rst = 1'b0;
        step(1'b1, 2'd1, 6'd9, 32'd0, 25'd0, 1'b0, 32'h600DD00D);
        idle(1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 6'($urandom),
                 $urandom, 25'($urandom), 1'($urandom_range(0, 2) == 0), $urandom);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
